multi_channel_scope: RTL and testbench

//  Parametrised successor to the single-pin oscilloscope: captures CHANNELS input pins into a circular

---
 rtl/multi_channel_scope_pkg.sv | 26 ++
 rtl/multi_channel_scope_if.sv | 13 +
 rtl/multi_channel_scope_ram.sv | 25 ++
 rtl/multi_channel_scope.sv | 170 +++++++++++++++++
 tb/tb_multi_channel_scope.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_channel_scope_pkg.sv
// Shared constants for the multi-channel scope: command opcodes, dump header,
// FSM state encoding and trigger-mode encoding.
package multi_channel_scope_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t OP_ARM   = 8'h41;
  localparam byte_t OP_ABORT = 8'h53;
  localparam byte_t OP_DIV   = 8'h44;
  localparam byte_t OP_TRIG  = 8'h54;
  localparam byte_t HDR_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PRETRIG = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_POST    = 3'd3;
  localparam logic [2:0] ST_DUMP    = 3'd4;

  typedef enum logic [1:0] {
    TM_RISE   = 2'b00,
    TM_FALL   = 2'b01,
    TM_EITHER = 2'b10,
    TM_IMM    = 2'b11
  } trig_mode_t;

endpackage

// File: rtl/multi_channel_scope_if.sv
// Byte-wide command/stream link between the scope and avr_interface.
interface multi_channel_scope_if;
  import multi_channel_scope_pkg::*;

  byte_t rx_data;
  logic  new_rx_data;
  byte_t tx_data;
  logic  new_tx_data;
  logic  tx_busy;

  modport master (output rx_data, new_rx_data, tx_busy, input tx_data, new_tx_data);
  modport slave  (input rx_data, new_rx_data, tx_busy, output tx_data, new_tx_data);
endinterface

// File: rtl/multi_channel_scope_ram.sv
// Simple dual-port sample buffer, one write and one registered read port.
module multi_channel_scope_ram
  import multi_channel_scope_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);
  byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/multi_channel_scope.sv
// Multi-channel logic scope: synchronizes probe pins, captures around a
// channel-edge trigger into a circular buffer and streams it over the tx link.
module multi_channel_scope
  import multi_channel_scope_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 512,
  parameter int DIV_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] input_pins,
  multi_channel_scope_if.slave bus,
  output logic                armed,
  output logic                triggered
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PRE_LAST  = AW'(DEPTH/2 - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH/2 - 2);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_BYTE = (AW+1)'(DEPTH - 1);

  logic [CHANNELS-1:0] sync_p0, sync_p1;
  byte_t               sample, prev_sample, ram_rdata, tx_byte;
  logic [2:0]          state, trig_ch;
  trig_mode_t          trig_mode;
  logic [DIV_W-1:0]    div, div_cnt;
  logic                arg_pending, arg_is_div;
  logic [AW-1:0]       wr_ptr, rd_ptr, phase_cnt;
  logic [AW:0]         rd_issued, tx_sent;
  logic                hdr_sent, buf_vld, tx_pulse;
  logic                stb, cmd_vld, abort, arm, ram_we, ram_re;
  logic                can_send, in_dump, send_hdr, send_data;

  function automatic logic trig_hit(input byte_t cur, input byte_t old,
                                    input logic [2:0] ch, input trig_mode_t mode);
    logic ch_ok, rise, fall;
    ch_ok = int'(ch) < CHANNELS;
    rise  = ch_ok & ~old[ch] & cur[ch];
    fall  = ch_ok & old[ch] & ~cur[ch];
    case (mode)
      TM_RISE:   return rise;
      TM_FALL:   return fall;
      TM_EITHER: return rise | fall;
      default:   return 1'b1;
    endcase
  endfunction

  // Stage p0/p1: two-flop synchronizer on the asynchronous probe pins
  always_ff @(posedge clk) begin
    sync_p0 <= input_pins;
    sync_p1 <= sync_p0;
    if (ram_we) prev_sample <= sample;
  end

  assign sample    = 8'(sync_p1);
  assign stb       = (div_cnt >= div);
  assign cmd_vld   = bus.new_rx_data & ~arg_pending;
  assign abort     = cmd_vld && (bus.rx_data == OP_ABORT);
  assign arm       = cmd_vld && (bus.rx_data == OP_ARM) && (state == ST_IDLE);
  assign armed     = (state == ST_PRETRIG) || (state == ST_WAIT) || (state == ST_POST);
  assign triggered = (state == ST_POST) || (state == ST_DUMP);
  assign ram_we    = armed & stb & ~abort;
  assign can_send  = ~bus.tx_busy & ~tx_pulse;
  assign in_dump   = (state == ST_DUMP) & ~abort;
  assign send_hdr  = in_dump & ~hdr_sent & can_send;
  assign send_data = in_dump & hdr_sent & buf_vld & can_send;
  // rdata doubles as the prefetch buffer: refill whenever it is empty or being consumed
  assign ram_re    = in_dump && (rd_issued != DEPTH_CNT) && (!buf_vld || send_data);

  assign bus.tx_data     = tx_byte;
  assign bus.new_tx_data = tx_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      div         <= '0;
      div_cnt     <= '0;
      trig_ch     <= '0;
      trig_mode   <= TM_RISE;
      arg_pending <= 1'b0;
      arg_is_div  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      phase_cnt   <= '0;
      rd_issued   <= '0;
      tx_sent     <= '0;
      hdr_sent    <= 1'b0;
      buf_vld     <= 1'b0;
      tx_pulse    <= 1'b0;
      tx_byte     <= '0;
    end else begin
      tx_pulse <= 1'b0;
      div_cnt  <= stb ? '0 : div_cnt + 1'b1;
      if (bus.new_rx_data) begin
        if (arg_pending) begin
          arg_pending <= 1'b0;
          if (state == ST_IDLE) begin
            if (arg_is_div) div <= DIV_W'(bus.rx_data);
            else begin
              trig_ch   <= bus.rx_data[2:0];
              trig_mode <= trig_mode_t'(bus.rx_data[4:3]);
            end
          end
        end else if (bus.rx_data == OP_DIV || bus.rx_data == OP_TRIG) begin
          arg_pending <= 1'b1;
          arg_is_div  <= (bus.rx_data == OP_DIV);
        end
      end
      if (ram_we) wr_ptr <= wr_ptr + 1'b1;
      if (abort) state <= ST_IDLE;
      else begin
        case (state)
          ST_IDLE: if (arm) begin
            state     <= ST_PRETRIG;
            div_cnt   <= '0;
            phase_cnt <= '0;
          end
          ST_PRETRIG: if (stb) begin
            phase_cnt <= phase_cnt + 1'b1;
            if (phase_cnt == PRE_LAST) state <= ST_WAIT;
          end
          ST_WAIT: if (stb && trig_hit(sample, prev_sample, trig_ch, trig_mode)) begin
            state     <= ST_POST;
            phase_cnt <= '0;
          end
          ST_POST: if (stb) begin
            phase_cnt <= phase_cnt + 1'b1;
            if (phase_cnt == POST_LAST) begin
              state     <= ST_DUMP;
              rd_ptr    <= wr_ptr + 1'b1;
              rd_issued <= '0;
              tx_sent   <= '0;
              hdr_sent  <= 1'b0;
              buf_vld   <= 1'b0;
            end
          end
          ST_DUMP: begin
            if (ram_re) begin
              rd_ptr    <= rd_ptr + 1'b1;
              rd_issued <= rd_issued + 1'b1;
              buf_vld   <= 1'b1;
            end else if (send_data) buf_vld <= 1'b0;
            if (send_hdr) begin
              tx_byte  <= HDR_BYTE;
              tx_pulse <= 1'b1;
              hdr_sent <= 1'b1;
            end else if (send_data) begin
              tx_byte  <= ram_rdata;
              tx_pulse <= 1'b1;
              tx_sent  <= tx_sent + 1'b1;
              if (tx_sent == LAST_BYTE) state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  multi_channel_scope_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (sample),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_multi_channel_scope.sv
// Directed/randomized bench for multi_channel_scope with DEPTH=16, CHANNELS=4.
module tb_multi_channel_scope;
  import multi_channel_scope_pkg::*;

  localparam int CH    = 4;
  localparam int DEPTH = 16;
  localparam int DIV_W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] pins;
  logic          armed, triggered;

  multi_channel_scope_if bus();

  multi_channel_scope #(.CHANNELS(CH), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .input_pins (pins),
    .bus        (bus),
    .armed      (armed),
    .triggered  (triggered)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  int            hs_viol = 0;
  byte_t         got[$];
  logic [CH-1:0] log_q[$];
  int            pin_mode = 0;
  int            busy_mode = 0;
  logic          ch0_val = 1'b0;
  logic          prev_busy = 1'b0;
  logic          prev_pulse = 1'b0;
  byte_t         last_tx = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe the tx link just after the edge, then drive next inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.new_tx_data) begin
      got.push_back(bus.tx_data);
      if (prev_busy || prev_pulse) hs_viol++;
    end else if (!rst && bus.tx_data !== last_tx) hs_viol++;
    prev_pulse = bus.new_tx_data;
    last_tx = bus.tx_data;
    case (pin_mode)
      1: pins = pins + 1'b1;
      2: begin pins = CH'($urandom()); pins[0] = ch0_val; end
      default: pins[0] = ch0_val;
    endcase
    log_q.push_back(pins);
    case (busy_mode)
      1: bus.tx_busy = ($urandom_range(0, 3) == 0);
      2: bus.tx_busy = 1'b1;
      default: bus.tx_busy = 1'b0;
    endcase
    prev_busy = bus.tx_busy;
  endtask

  task automatic send_cmd(input byte_t b);
    bus.rx_data = b;
    bus.new_rx_data = 1'b1;
    tick();
    bus.new_rx_data = 1'b0;
  endtask

  task automatic set_cfg(input byte_t d, input byte_t t);
    send_cmd(OP_DIV);  send_cmd(d);
    send_cmd(OP_TRIG); send_cmd(t);
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int c = 0;
    while (got.size() < n && c < budget) begin tick(); c++; end
    check({tag, "_count"}, got.size(), n);
  endtask

  // Header, then each dumped sample must step by `step` (mod 16) with upper bits zero.
  task automatic check_steps(input string tag, input int step);
    check({tag, "_hdr"}, got[0], HDR_BYTE);
    for (int i = 1; i < DEPTH; i++)
      check({tag, "_step"}, (got[i+1] - got[i]) & 8'h0F, step);
    for (int i = 1; i <= DEPTH; i++)
      check({tag, "_hi"}, got[i] >> CH, 0);
  endtask

  function automatic int last_rise();
    int k = -1;
    for (int i = 1; i < log_q.size(); i++)
      if (log_q[i][0] && !log_q[i-1][0]) k = i;
    return k;
  endfunction

  // With div=0 every clock is a sample, so the dump is DEPTH consecutive driven
  // values with the trigger (last ch0 rise) at index DEPTH/2.
  task automatic check_dump(input string tag);
    int k = last_rise();
    check({tag, "_hdr"}, got[0], HDR_BYTE);
    for (int i = 0; i < DEPTH; i++) begin
      int idx = k - DEPTH/2 + i;
      byte_t e = 8'hFF;
      if (k >= 0 && idx >= 0 && idx < log_q.size()) e = 8'(log_q[idx]);
      check({tag, "_byte"}, got[i+1], e);
    end
  endtask

  task automatic check_idle_after(input string tag);
    repeat (20) tick();
    check({tag, "_armed"}, armed, 0);
    check({tag, "_trig"}, triggered, 0);
    check({tag, "_nomore"}, got.size(), DEPTH + 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int c;
    bus.rx_data = 8'h00; bus.new_rx_data = 1'b0; bus.tx_busy = 1'b0;
    pins = '0;

    // reset state
    tick(); tick();
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_new_tx", bus.new_tx_data, 0);
    check("rst_armed", armed, 0);
    check("rst_trig", triggered, 0);
    rst = 1'b0;
    tick();

    // arm with default config, constant pins never trigger
    send_cmd(OP_ARM);
    check("arm_armed", armed, 1);
    repeat (40) tick();
    check("arm_no_tx", got.size(), 0);
    check("arm_no_trig", triggered, 0);
    send_cmd(OP_ABORT);
    check("arm_abort", armed, 0);

    // rising edge on ch0 with random other channels
    set_cfg(8'h00, 8'h00);
    got.delete(); log_q.delete();
    pin_mode = 2; ch0_val = 1'b0; busy_mode = 1;
    send_cmd(OP_ARM);
    repeat (30) tick();
    ch0_val = 1'b1;
    wait_bytes(DEPTH + 1, 400, "rise");
    check_dump("rise");
    check("rise_b8_bit0", got[9][0], 1);
    check("rise_b7_bit0", got[8][0], 0);
    check_idle_after("rise");

    // immediate trigger, div=3 on a free-running counter
    set_cfg(8'h03, 8'h18);
    got.delete();
    pin_mode = 1;
    send_cmd(OP_ARM);
    wait_bytes(DEPTH + 1, 600, "imm_div3");
    check_steps("imm_div3", 4);
    check_idle_after("imm_div3");

    // tx_busy held high for 100 cycles mid-dump
    set_cfg(8'h00, 8'h18);
    got.delete();
    send_cmd(OP_ARM);
    wait_bytes(5, 300, "busy_pre");
    busy_mode = 2;
    tick();
    n0 = got.size();
    repeat (100) tick();
    check("busy_stall", got.size(), n0);
    busy_mode = 0;
    wait_bytes(DEPTH + 1, 300, "busy_post");
    check_steps("busy", 1);
    check_idle_after("busy");

    // abort while waiting for trigger
    set_cfg(8'h00, 8'h00);
    got.delete();
    pin_mode = 2; ch0_val = 1'b0; busy_mode = 1;
    send_cmd(OP_ARM);
    repeat (30) tick();
    check("wait_armed", armed, 1);
    check("wait_trig", triggered, 0);
    send_cmd(OP_ABORT);
    check("wabort_armed", armed, 0);
    ch0_val = 1'b1;
    repeat (40) tick();
    check("wabort_trig", triggered, 0);
    check("wabort_notx", got.size(), 0);

    // abort after five dump bytes
    set_cfg(8'h00, 8'h18);
    got.delete();
    pin_mode = 1;
    send_cmd(OP_ARM);
    wait_bytes(5, 300, "dabort_pre");
    n0 = got.size();
    send_cmd(OP_ABORT);
    check("dabort_armed", armed, 0);
    check("dabort_trig", triggered, 0);
    repeat (50) tick();
    check("dabort_notx", got.size(), n0);

    // 0x41 after 'D' is an argument, not an arm
    send_cmd(OP_DIV); send_cmd(OP_ARM);
    check("darg_noarm", armed, 0);
    send_cmd(OP_TRIG); send_cmd(8'h18);
    got.delete();
    send_cmd(OP_ARM);
    wait_bytes(DEPTH + 1, 2500, "div41");
    check_steps("div41", 2);
    check_idle_after("div41");

    // ch0 edge during PRETRIG is ignored; a later edge triggers
    set_cfg(8'h00, 8'h00);
    got.delete(); log_q.delete();
    pin_mode = 2; ch0_val = 1'b0;
    send_cmd(OP_ARM);
    ch0_val = 1'b1;
    repeat (20) tick();
    check("pre_edge_ignored", triggered, 0);
    ch0_val = 1'b0;
    repeat (10) tick();
    ch0_val = 1'b1;
    wait_bytes(DEPTH + 1, 400, "pre_edge");
    check_dump("pre_edge");
    check_idle_after("pre_edge");

    // rst during POSTTRIG restores defaults and clears a pending argument
    set_cfg(8'h05, 8'h00);
    got.delete();
    ch0_val = 1'b0;
    send_cmd(OP_ARM);
    repeat (80) tick();
    ch0_val = 1'b1;
    c = 0;
    while (!triggered && c < 40) begin tick(); c++; end
    check("post_trig", triggered, 1);
    send_cmd(OP_DIV);
    repeat (3) tick();
    check("post_armed", armed, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("prst_armed", armed, 0);
    check("prst_trig", triggered, 0);
    check("prst_new_tx", bus.new_tx_data, 0);
    check("prst_tx_data", bus.tx_data, 0);
    got.delete();
    pin_mode = 1;
    send_cmd(OP_ARM);
    check("prst_rearm", armed, 1);
    wait_bytes(DEPTH + 1, 400, "prst");
    check_steps("prst", 1);
    check("prst_trig_bit0", got[9][0], 1);
    check_idle_after("prst");

    check("handshake", hs_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
